// File: rtl/ce_divider_chain_pkg.sv
// Shared constants for the clock-enable divider chain.
// Holds clock rate, counter width, display/second divide values and a ratio helper.
package ce_div_pkg;

    localparam int CLK_HZ   = 40_000_000;
    localparam int CEDIV_W  = 26;
    localparam int DIV_SCAN = 39_999;
    localparam int DIV_SEC  = 999;

    // Divide values are stored as ratio-1 so that cnt==div marks the wrap.
    function automatic int unsigned ratio_to_div(input int unsigned r);
        return r - 1;
    endfunction

endpackage

// File: rtl/ce_divider_chain_if.sv
// Control/status bundle of the divider chain.
// master: EN, CLR, LD_VAL, LD_REQ out; LD_ACK, CEOUT (and TGL with CEDIV_TOGGLE_EN) in.
interface ce_divider_chain_if
    import ce_div_pkg::*;
#(
    parameter int NCH = 2,
    parameter int W   = CEDIV_W
);
    logic             EN;
    logic             CLR;
    logic [NCH*W-1:0] LD_VAL;
    logic [NCH-1:0]   LD_REQ;
    logic [NCH-1:0]   LD_ACK;
    logic [NCH-1:0]   CEOUT;
`ifdef CEDIV_TOGGLE_EN
    logic [NCH-1:0]   TGL;
`endif

    modport master (
        output EN, CLR, LD_VAL, LD_REQ,
        input  LD_ACK, CEOUT
`ifdef CEDIV_TOGGLE_EN
        , input TGL
`endif
    );

    modport slave (
        input  EN, CLR, LD_VAL, LD_REQ,
        output LD_ACK, CEOUT
`ifdef CEDIV_TOGGLE_EN
        , output TGL
`endif
    );

endinterface

// File: rtl/ce_divider_chain_stage.sv
// One divider stage: counts ticks, pulses ceout on wrap, adopts new divide on wrap/clr.
// Ports: clk, rst, tick, clr, ld_req, ld_val in; ceout, ld_ack (tgl with CEDIV_TOGGLE_EN) out.
module ce_div_stage
    import ce_div_pkg::*;
#(
    parameter int           W       = CEDIV_W,
    parameter logic [W-1:0] DIV_RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         clr,
    input  logic         ld_req,
    input  logic [W-1:0] ld_val,
`ifdef CEDIV_TOGGLE_EN
    output logic         tgl,
`endif
    output logic         ceout,
    output logic         ld_ack
);

    logic [W-1:0] cnt;
    logic [W-1:0] div;
    logic [W-1:0] shadow;
    logic         pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div     <= DIV_RST;
            shadow  <= '0;
            pending <= 1'b0;
            ceout   <= 1'b0;
            ld_ack  <= 1'b0;
        end else begin
            ceout  <= 1'b0;
            ld_ack <= 1'b0;
            if (clr) begin
                cnt <= '0;
                if (pending) begin
                    div     <= shadow;
                    pending <= 1'b0;
                    ld_ack  <= 1'b1;
                end
            end else if (tick) begin
                if (cnt == div) begin
                    cnt   <= '0;
                    ceout <= 1'b1;
                    if (pending) begin
                        div     <= shadow;
                        pending <= 1'b0;
                        ld_ack  <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            // A request on an adopt edge is captured and waits for the next wrap.
            if (ld_req) begin
                shadow  <= ld_val;
                pending <= 1'b1;
            end
        end
    end

`ifdef CEDIV_TOGGLE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tgl <= 1'b0;
        else if (clr)
            tgl <= 1'b0;
        else if (ceout)
            tgl <= ~tgl;
    end
`endif

endmodule

// File: rtl/ce_divider_chain.sv
// Cascade of clock-enable dividers; stage 0 counts EN cycles, stage k counts CEOUT[k-1].
// Ports: CLK, RST (async, active-high), bus (slave). Option: CEDIV_TOGGLE_EN adds bus.TGL.
module ce_divider_chain
    import ce_div_pkg::*;
#(
    parameter int               NCH      = 2,
    parameter int               W        = CEDIV_W,
    parameter logic [NCH*W-1:0] DIV_INIT = {W'(DIV_SEC), W'(DIV_SCAN)}
) (
    input  logic                CLK,
    input  logic                RST,
    ce_divider_chain_if.slave   bus
);

    logic [NCH-1:0] tick;
    logic [NCH-1:0] ceout;
    logic [NCH-1:0] ack;
`ifdef CEDIV_TOGGLE_EN
    logic [NCH-1:0] tgl;
    assign bus.TGL = tgl;
`endif

    assign bus.CEOUT  = ceout;
    assign bus.LD_ACK = ack;

    for (genvar k = 0; k < NCH; k++) begin : g_stage
        if (k == 0) begin : g_t0
            assign tick[k] = bus.EN;
        end else begin : g_tk
            assign tick[k] = ceout[k-1];
        end

        ce_div_stage #(
            .W       (W),
            .DIV_RST (DIV_INIT[k*W +: W])
        ) u_stage (
            .clk    (CLK),
            .rst    (RST),
            .tick   (tick[k]),
            .clr    (bus.CLR),
            .ld_req (bus.LD_REQ[k]),
            .ld_val (bus.LD_VAL[k*W +: W]),
`ifdef CEDIV_TOGGLE_EN
            .tgl    (tgl[k]),
`endif
            .ceout  (ceout[k]),
            .ld_ack (ack[k])
        );
    end

endmodule
